seq_cb_adder: RTL

- Multi-cycle, parametrised carry-bypass adder/subtractor.
- Processes one SEG-bit segment per clock, LSB segment first, through a combinational carry-bypass datapath built from BLOCK-bit skip groups. A registered carry links consecutive segments.
- Valid/ready handshakes on input and output let it sit between pipeline stages that need wide adds and cannot afford a full-width carry chain.
- Adds subtract mode, signed-overflow and zero flags, and output backpressure, none of which the purely combinational adders have.

---
 rtl/seq_cb_adder_if.sv | 31 +++
 rtl/seq_cb_adder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seq_cb_adder_if.sv
// seq_cb_adder_if: operand/result handshake bundle for seq_cb_adder.
//   master : requester side (drives operands, in_valid, out_ready)
//   slave  : adder side (drives in_ready, out_valid, sum and flags)
//   in_valid/in_ready   operand handshake; a, b, cin, sub operands
//   out_valid/out_ready result handshake; sum, cout, ovf, zero results
interface seq_cb_adder_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/seq_cb_adder.sv
// seq_cb_adder: multi-cycle carry-bypass adder/subtractor.
// One SEG-bit segment is summed per clock (LSB segment first) by a
// carry-bypass datapath of BLOCK-bit skip groups; a registered carry links
// consecutive segments. Result appears NSEG cycles after acceptance.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  seq_cb_adder_if.slave: in_valid/in_ready, a, b, cin, sub,
//        out_valid/out_ready, sum, cout (borrow in sub mode), ovf, zero
module seq_cb_adder #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16,
    parameter int BLOCK = 4
) (
    input  logic          clk,
    input  logic          rst,
    seq_cb_adder_if.slave bus
);
    localparam int NSEG = WIDTH / SEG;
    localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [CW-1:0] LAST_SEG = CW'(NSEG - 1);
    localparam int unsigned NGRP_U  = SEG / BLOCK;
    localparam int unsigned BLK_U   = BLOCK;
    localparam int unsigned MSB_BIT = SEG - 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (WIDTH <= 0 || SEG <= 0 || BLOCK <= 0 ||
            (WIDTH % SEG) != 0 || (SEG % BLOCK) != 0) begin : g_bad_params
            $error("seq_cb_adder: WIDTH must be a multiple of SEG and SEG a multiple of BLOCK");
        end
    endgenerate

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;      // already inverted in subtract mode
    logic             sub_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    logic [SEG-1:0]   seg_a;
    logic [SEG-1:0]   seg_b;
    logic [SEG-1:0]   seg_s;
    logic             seg_co;
    logic             msb_ci;
    logic             c;
    logic             grp_ci;
    logic             all_p;
    logic             bit_p;
    int unsigned      seg_lo;
    int unsigned      idx;
    logic [WIDTH-1:0] nxt_sum;

    // Segment datapath: ripple inside each group, then skip the group's
    // ripple result when every propagate bit is set.
    always_comb begin
        seg_lo = 32'(cnt) * 32'(SEG);
        seg_a  = a_r[seg_lo +: SEG];
        seg_b  = b_r[seg_lo +: SEG];
        seg_s  = '0;
        msb_ci = 1'b0;
        c      = carry;
        grp_ci = 1'b0;
        all_p  = 1'b0;
        bit_p  = 1'b0;
        idx    = 0;
        for (int unsigned gi = 0; gi < NGRP_U; gi++) begin
            grp_ci = c;
            all_p  = 1'b1;
            for (int unsigned bi = 0; bi < BLK_U; bi++) begin
                idx        = gi * BLK_U + bi;
                bit_p      = seg_a[idx] ^ seg_b[idx];
                seg_s[idx] = bit_p ^ c;
                if (idx == MSB_BIT) begin
                    msb_ci = c;
                end
                c     = (seg_a[idx] & seg_b[idx]) | (bit_p & c);
                all_p = all_p & bit_p;
            end
            if (all_p) begin
                c = grp_ci;
            end
        end
        seg_co  = c;
        nxt_sum = sum_r;
        nxt_sum[seg_lo +: SEG] = seg_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            sub_r  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b ^ {WIDTH{bus.sub}};
                        sub_r <= bus.sub;
                        carry <= bus.cin ^ bus.sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r <= nxt_sum;
                    carry <= seg_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_SEG) begin
                        // msb_ci/seg_co here are the raw carries around bit WIDTH-1
                        cout_r <= seg_co ^ sub_r;
                        ovf_r  <= msb_ci ^ seg_co;
                        zero_r <= (nxt_sum == '0);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // in_ready is masked by rst so it stays low for the whole reset cycle,
    // even once state has already returned to IDLE.
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;
endmodule
